// File: rtl/st_timing_adapter_rl.sv
// Avalon-ST timing adapter: upstream ready latency IN_READY_LATENCY -> downstream latency 0.
// Optional packet sideband (sop/eop + pkt_count) enabled by ST_TIMING_ADAPTER_PKT_EN.
module st_timing_adapter_rl #(
    parameter int unsigned DATA_W           = 256,
    parameter int unsigned DEPTH            = 8,
    parameter int unsigned IN_READY_LATENCY = 0,
    parameter int unsigned ALMOST_FULL      = 6
) (
    input  logic                       clk,
    input  logic                       reset,
    output logic                       in_ready,
    input  logic                       in_valid,
    input  logic [DATA_W-1:0]          in_data,
    input  logic                       out_ready,
    output logic                       out_valid,
    output logic [DATA_W-1:0]          out_data,
    output logic [$clog2(DEPTH):0]     fill_level,
    output logic                       almost_full,
    output logic                       overflow,
`ifdef ST_TIMING_ADAPTER_PKT_EN
    input  logic                       in_startofpacket,
    input  logic                       in_endofpacket,
    output logic                       out_startofpacket,
    output logic                       out_endofpacket,
    output logic [$clog2(DEPTH):0]     pkt_count,
`endif
    input  logic                       clr_overflow
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
`ifdef ST_TIMING_ADAPTER_PKT_EN
    localparam int unsigned ENTRY_W = DATA_W + 2;
`else
    localparam int unsigned ENTRY_W = DATA_W;
`endif
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] RL_C    = CNT_W'(IN_READY_LATENCY);
    localparam logic [CNT_W-1:0] AF_C    = CNT_W'(ALMOST_FULL);

    logic [ENTRY_W-1:0] mem [DEPTH];
    logic [ENTRY_W-1:0] wr_entry;
    logic [ENTRY_W-1:0] rd_entry;

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] space;
    logic             overflow_q, overflow_d;
    // Holds in_ready low from reset assertion until the first edge after release.
    logic             ready_en_q;
    logic             push_req, push, pop, drop;

    always_comb begin
        space     = DEPTH_C - count_q;
        in_ready  = ready_en_q && (space > RL_C);
        out_valid = (count_q != '0);
        pop       = out_valid && out_ready;
        // With RL>0 the upstream only asserts valid in granted slots, so valid alone is a push.
        push_req  = (IN_READY_LATENCY == 0) ? (in_valid && in_ready) : in_valid;
        push      = push_req && ((count_q != DEPTH_C) || pop);
        drop      = push_req && (count_q == DEPTH_C) && !pop;

        wr_ptr_d  = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d  = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        count_d   = count_q;
        if (push && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (pop && !push) begin
            count_d = count_q - CNT_W'(1);
        end

        overflow_d = overflow_q;
        if (drop) begin
            overflow_d = 1'b1;
        end else if (clr_overflow) begin
            overflow_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            ready_en_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            ready_en_q <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= wr_entry;
        end
    end

    assign rd_entry    = mem[rd_ptr_q];
    assign out_data    = rd_entry[DATA_W-1:0];
    assign fill_level  = count_q;
    assign almost_full = (count_q >= AF_C);
    assign overflow    = overflow_q;

`ifdef ST_TIMING_ADAPTER_PKT_EN
    logic [CNT_W-1:0] pkt_count_q, pkt_count_d;
    logic             eop_in, eop_out;

    assign wr_entry          = {in_startofpacket, in_endofpacket, in_data};
    assign out_startofpacket = rd_entry[DATA_W+1];
    assign out_endofpacket   = rd_entry[DATA_W];
    assign pkt_count         = pkt_count_q;

    always_comb begin
        eop_in      = push && in_endofpacket;
        eop_out     = pop && out_endofpacket;
        pkt_count_d = pkt_count_q;
        if (eop_in && !eop_out) begin
            pkt_count_d = pkt_count_q + CNT_W'(1);
        end else if (eop_out && !eop_in) begin
            pkt_count_d = pkt_count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pkt_count_q <= '0;
        end else begin
            pkt_count_q <= pkt_count_d;
        end
    end
`else
    assign wr_entry = in_data;
`endif

endmodule

// File: tb/tb_st_timing_adapter_rl.sv
// Directed bench for st_timing_adapter_rl: three instances with ready latency 0, 2 and 1.
// Packet sideband checks are compiled in when ST_TIMING_ADAPTER_PKT_EN is defined.
module tb_st_timing_adapter_rl;

    localparam int unsigned DW = 16;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    // a: RL=0, b: RL=2, c: RL=1
    logic          a_in_ready, a_in_valid, a_out_ready, a_out_valid, a_af, a_ovf, a_clr;
    logic          b_in_ready, b_in_valid, b_out_ready, b_out_valid, b_af, b_ovf, b_clr;
    logic          c_in_ready, c_in_valid, c_out_ready, c_out_valid, c_af, c_ovf, c_clr;
    logic [DW-1:0] a_in_data, a_out_data, b_in_data, b_out_data, c_in_data, c_out_data;
    logic [3:0]    a_fill, b_fill, c_fill;
`ifdef ST_TIMING_ADAPTER_PKT_EN
    logic       a_isop, a_ieop, a_osop, a_oeop, b_isop, b_ieop, b_osop, b_oeop;
    logic       c_isop, c_ieop, c_osop, c_oeop;
    logic [3:0] a_pkt, b_pkt, c_pkt;
`endif

    st_timing_adapter_rl #(.DATA_W(DW), .DEPTH(8), .IN_READY_LATENCY(0), .ALMOST_FULL(6)) u_a (
        .clk(clk), .reset(reset), .in_ready(a_in_ready), .in_valid(a_in_valid),
        .in_data(a_in_data), .out_ready(a_out_ready), .out_valid(a_out_valid),
        .out_data(a_out_data), .fill_level(a_fill), .almost_full(a_af), .overflow(a_ovf),
`ifdef ST_TIMING_ADAPTER_PKT_EN
        .in_startofpacket(a_isop), .in_endofpacket(a_ieop), .out_startofpacket(a_osop),
        .out_endofpacket(a_oeop), .pkt_count(a_pkt),
`endif
        .clr_overflow(a_clr)
    );

    st_timing_adapter_rl #(.DATA_W(DW), .DEPTH(8), .IN_READY_LATENCY(2), .ALMOST_FULL(6)) u_b (
        .clk(clk), .reset(reset), .in_ready(b_in_ready), .in_valid(b_in_valid),
        .in_data(b_in_data), .out_ready(b_out_ready), .out_valid(b_out_valid),
        .out_data(b_out_data), .fill_level(b_fill), .almost_full(b_af), .overflow(b_ovf),
`ifdef ST_TIMING_ADAPTER_PKT_EN
        .in_startofpacket(b_isop), .in_endofpacket(b_ieop), .out_startofpacket(b_osop),
        .out_endofpacket(b_oeop), .pkt_count(b_pkt),
`endif
        .clr_overflow(b_clr)
    );

    st_timing_adapter_rl #(.DATA_W(DW), .DEPTH(8), .IN_READY_LATENCY(1), .ALMOST_FULL(6)) u_c (
        .clk(clk), .reset(reset), .in_ready(c_in_ready), .in_valid(c_in_valid),
        .in_data(c_in_data), .out_ready(c_out_ready), .out_valid(c_out_valid),
        .out_data(c_out_data), .fill_level(c_fill), .almost_full(c_af), .overflow(c_ovf),
`ifdef ST_TIMING_ADAPTER_PKT_EN
        .in_startofpacket(c_isop), .in_endofpacket(c_ieop), .out_startofpacket(c_osop),
        .out_endofpacket(c_oeop), .pkt_count(c_pkt),
`endif
        .clr_overflow(c_clr)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #3;
        checks++; if (a_in_ready !== 1'b0 || b_in_ready !== 1'b0 || c_in_ready !== 1'b0) begin
            errors++; $display("FAIL reset_in_ready: got %b%b%b expected 000",
                               a_in_ready, b_in_ready, c_in_ready); end
        checks++; if (a_out_valid !== 1'b0 || a_fill !== 4'd0 || a_af !== 1'b0 || a_ovf !== 1'b0) begin
            errors++; $display("FAIL reset_state: got valid=%b fill=%0d af=%b ovf=%b expected 0 0 0 0",
                               a_out_valid, a_fill, a_af, a_ovf); end
        @(negedge clk);
        reset = 1'b0;
        tick();
        checks++; if (a_in_ready !== 1'b1 || b_in_ready !== 1'b1 || c_in_ready !== 1'b1) begin
            errors++; $display("FAIL release_in_ready: got %b%b%b expected 111",
                               a_in_ready, b_in_ready, c_in_ready); end
    endtask

    task automatic test_fill_drain();
        a_out_ready = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            a_in_valid = 1'b1;
            a_in_data  = DW'(i);
            tick();
            checks++; if (a_fill !== 4'(i) || a_af !== (i >= 6) || a_in_ready !== (i < 8)) begin
                errors++; $display("FAIL fill[%0d]: got fill=%0d af=%b rdy=%b expected %0d %b %b",
                                   i, a_fill, a_af, a_in_ready, i, (i >= 6), (i < 8)); end
        end
        a_in_valid  = 1'b0;
        a_out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            checks++; if (a_out_valid !== 1'b1 || a_out_data !== DW'(i)) begin
                errors++; $display("FAIL drain_data[%0d]: got v=%b d=%0h expected 1 %0h",
                                   i, a_out_valid, a_out_data, i); end
            tick();
            checks++; if (a_fill !== 4'(8 - i)) begin
                errors++; $display("FAIL drain_fill[%0d]: got %0d expected %0d", i, a_fill, 8 - i); end
        end
        a_out_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        a_in_valid  = 1'b1;
        a_out_ready = 1'b1;
        a_in_data   = 16'h0100;
        tick();
        for (int k = 1; k <= 6; k++) begin
            a_in_data = 16'h0100 + DW'(k);
            checks++; if (a_out_valid !== 1'b1 || a_out_data !== 16'h0100 + DW'(k - 1)) begin
                errors++; $display("FAIL b2b_data[%0d]: got v=%b d=%0h expected 1 %0h",
                                   k, a_out_valid, a_out_data, 16'h0100 + k - 1); end
            tick();
            checks++; if (a_fill !== 4'd1) begin
                errors++; $display("FAIL b2b_fill[%0d]: got %0d expected 1", k, a_fill); end
        end
        a_in_valid = 1'b0;
        tick();
        checks++; if (a_fill !== 4'd0 || a_out_valid !== 1'b0) begin
            errors++; $display("FAIL b2b_empty: got fill=%0d v=%b expected 0 0", a_fill, a_out_valid); end
        a_out_ready = 1'b0;
    endtask

    task automatic test_rl2_overflow();
        b_out_ready = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            checks++; if (b_in_ready !== 1'b1) begin
                errors++; $display("FAIL rl2_ready[%0d]: got %b expected 1", i, b_in_ready); end
            b_in_valid = 1'b1;
            b_in_data  = DW'(i);
            tick();
        end
        checks++; if (b_in_ready !== 1'b0 || b_fill !== 4'd6) begin
            errors++; $display("FAIL rl2_ready_drop: got rdy=%b fill=%0d expected 0 6", b_in_ready, b_fill); end
        b_in_data = 16'd7; tick();
        b_in_data = 16'd8; tick();
        checks++; if (b_fill !== 4'd8 || b_ovf !== 1'b0) begin
            errors++; $display("FAIL rl2_inflight: got fill=%0d ovf=%b expected 8 0", b_fill, b_ovf); end
        b_in_data = 16'd9; tick();
        checks++; if (b_fill !== 4'd8 || b_ovf !== 1'b1) begin
            errors++; $display("FAIL rl2_drop: got fill=%0d ovf=%b expected 8 1", b_fill, b_ovf); end
        b_in_data = 16'd10;
        b_clr     = 1'b1;
        tick();
        checks++; if (b_ovf !== 1'b1) begin
            errors++; $display("FAIL rl2_set_dominates: got %b expected 1", b_ovf); end
        b_in_valid = 1'b0;
        tick();
        checks++; if (b_ovf !== 1'b0) begin
            errors++; $display("FAIL rl2_clear: got %b expected 0", b_ovf); end
        b_clr       = 1'b0;
        b_out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            checks++; if (b_out_data !== DW'(i)) begin
                errors++; $display("FAIL rl2_order[%0d]: got %0h expected %0h", i, b_out_data, i); end
            tick();
        end
        checks++; if (b_fill !== 4'd0) begin
            errors++; $display("FAIL rl2_empty: got %0d expected 0", b_fill); end
        b_out_ready = 1'b0;
    endtask

    task automatic test_rl1_full_passthrough();
        c_out_ready = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            c_in_valid = 1'b1;
            c_in_data  = DW'(i);
            tick();
            if (i == 7) begin
                checks++; if (c_in_ready !== 1'b0) begin
                    errors++; $display("FAIL rl1_ready_at7: got %b expected 0", c_in_ready); end
            end
        end
        checks++; if (c_fill !== 4'd8) begin
            errors++; $display("FAIL rl1_full: got %0d expected 8", c_fill); end
        c_in_data   = 16'd9;
        c_out_ready = 1'b1;
        checks++; if (c_out_data !== 16'd1) begin
            errors++; $display("FAIL rl1_head: got %0h expected 1", c_out_data); end
        tick();
        checks++; if (c_fill !== 4'd8 || c_ovf !== 1'b0 || c_out_data !== 16'd2) begin
            errors++; $display("FAIL rl1_pushpop: got fill=%0d ovf=%b d=%0h expected 8 0 2",
                               c_fill, c_ovf, c_out_data); end
        c_in_valid = 1'b0;
        for (int i = 2; i <= 9; i++) begin
            checks++; if (c_out_data !== DW'(i)) begin
                errors++; $display("FAIL rl1_order[%0d]: got %0h expected %0h", i, c_out_data, i); end
            tick();
        end
        c_out_ready = 1'b0;
    endtask

    task automatic test_async_reset();
        a_out_ready = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            a_in_valid = 1'b1;
            a_in_data  = 16'h0E00 + DW'(i);
            tick();
        end
        a_in_valid = 1'b0;
        checks++; if (a_fill !== 4'd5) begin
            errors++; $display("FAIL arst_prefill: got %0d expected 5", a_fill); end
        #2;
        reset = 1'b1;
        #1;
        checks++; if (a_out_valid !== 1'b0 || a_fill !== 4'd0 || a_in_ready !== 1'b0) begin
            errors++; $display("FAIL arst_immediate: got v=%b fill=%0d rdy=%b expected 0 0 0",
                               a_out_valid, a_fill, a_in_ready); end
        @(negedge clk);
        reset = 1'b0;
        tick();
        a_in_valid = 1'b1;
        a_in_data  = 16'h00A5;
        tick();
        a_in_valid = 1'b0;
        checks++; if (a_fill !== 4'd1 || a_out_data !== 16'h00A5) begin
            errors++; $display("FAIL arst_first: got fill=%0d d=%0h expected 1 a5", a_fill, a_out_data); end
        a_out_ready = 1'b1;
        tick();
        a_out_ready = 1'b0;
        checks++; if (a_fill !== 4'd0) begin
            errors++; $display("FAIL arst_drain: got %0d expected 0", a_fill); end
    endtask

`ifdef ST_TIMING_ADAPTER_PKT_EN
    task automatic test_pkt();
        logic [DW-1:0] dat [4];
        logic [1:0]    flg [4];
        logic [3:0]    pk_push [4];
        logic [3:0]    pk_pop [4];
        dat = '{16'h11, 16'h12, 16'h13, 16'h14};
        flg = '{2'b10, 2'b00, 2'b01, 2'b11};
        pk_push = '{4'd0, 4'd0, 4'd1, 4'd2};
        pk_pop  = '{4'd2, 4'd2, 4'd1, 4'd0};
        a_out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            a_in_valid = 1'b1;
            a_in_data  = dat[i];
            {a_isop, a_ieop} = flg[i];
            tick();
            checks++; if (a_pkt !== pk_push[i]) begin
                errors++; $display("FAIL pkt_push[%0d]: got %0d expected %0d", i, a_pkt, pk_push[i]); end
        end
        a_in_valid = 1'b0;
        {a_isop, a_ieop} = 2'b00;
        a_out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checks++; if (a_out_data !== dat[i] || {a_osop, a_oeop} !== flg[i]) begin
                errors++; $display("FAIL pkt_beat[%0d]: got d=%0h f=%b expected %0h %b",
                                   i, a_out_data, {a_osop, a_oeop}, dat[i], flg[i]); end
            tick();
            checks++; if (a_pkt !== pk_pop[i]) begin
                errors++; $display("FAIL pkt_pop[%0d]: got %0d expected %0d", i, a_pkt, pk_pop[i]); end
        end
        a_out_ready = 1'b0;
    endtask
`endif

    initial begin
        a_in_valid = 1'b0; a_out_ready = 1'b0; a_clr = 1'b0; a_in_data = '0;
        b_in_valid = 1'b0; b_out_ready = 1'b0; b_clr = 1'b0; b_in_data = '0;
        c_in_valid = 1'b0; c_out_ready = 1'b0; c_clr = 1'b0; c_in_data = '0;
`ifdef ST_TIMING_ADAPTER_PKT_EN
        a_isop = 1'b0; a_ieop = 1'b0; b_isop = 1'b0; b_ieop = 1'b0;
        c_isop = 1'b0; c_ieop = 1'b0;
`endif
        test_reset();
        test_fill_drain();
        test_back_to_back();
        test_rl2_overflow();
        test_rl1_full_passthrough();
        test_async_reset();
`ifdef ST_TIMING_ADAPTER_PKT_EN
        test_pkt();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
